// File: rtl/unsigned_div_pkg.sv
`default_nettype none
// ============================================================================
// Module   : unsigned_div_pkg
// Purpose  : Shared widths and FSM state type for the sequential unsigned
//            16-by-8 restoring divider.
// Contents : c_w_x   - default dividend / quotient width
//            c_w_y   - default divisor / remainder width
//            c_cnt_w - step counter width for the default dividend width
//            state_t - divider FSM states
// Revision : 1.0 - initial release
// ============================================================================
package unsigned_div_pkg;

  localparam int c_w_x   = 16;
  localparam int c_w_y   = 8;
  localparam int c_cnt_w = $clog2(c_w_x);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage : unsigned_div_pkg
`default_nettype wire

// File: rtl/unsigned_div_16by8_seq_step.sv
`default_nettype none
// ============================================================================
// Module   : div_restore_step
// Purpose  : One combinational restoring-division step. Shifts the next
//            dividend bit into the partial remainder and subtracts the divisor
//            when it fits.
// Ports    : p_in   [W_Y:0]   partial remainder before the step
//            d_bit            next dividend bit (MSB first)
//            y      [W_Y-1:0] divisor
//            p_out  [W_Y:0]   partial remainder after the step
//            q_bit            quotient bit produced by this step
// Revision : 1.0 - initial release
// ============================================================================
module div_restore_step
  import unsigned_div_pkg::*;
#(
  parameter int W_Y = c_w_y
) (
  input  logic [W_Y:0]   p_in,
  input  logic           d_bit,
  input  logic [W_Y-1:0] y,
  output logic [W_Y:0]   p_out,
  output logic           q_bit
);

  logic [W_Y:0] w_shift;
  logic [W_Y:0] w_div;

  assign w_shift = {p_in[W_Y-1:0], d_bit};
  assign w_div   = {1'b0, y};

  always_comb begin
    // The remainder stays below the divisor, so p_in[W_Y] is always 0 in
    // normal operation. Should it ever be set, the true shifted value is
    // at least 2^(W_Y+1) and certainly exceeds y, so the bit is forced to 1;
    // the modulo subtraction then yields the correct reduced remainder.
    q_bit = p_in[W_Y] | (w_shift >= w_div);
    p_out = w_shift;
    if (q_bit) begin
      p_out = w_shift - w_div;
    end
  end

endmodule : div_restore_step
`default_nettype wire

// File: rtl/unsigned_div_16by8_seq.sv
`default_nettype none
// ============================================================================
// Module   : unsigned_div_16by8_seq
// Purpose  : Sequential unsigned restoring divider, one quotient bit per
//            cycle. q = floor(x/y), r = x mod y; y == 0 returns q = all ones,
//            r = 0, dz = 1 after a single cycle.
// Ports    : clk, rst_n            clock, asynchronous active-low reset
//            in_valid / in_ready   operand handshake (x, y)
//            out_valid / out_ready result handshake (q, r, dz)
// Revision : 1.0 - initial release
// ============================================================================
module unsigned_div_16by8_seq
  import unsigned_div_pkg::*;
#(
  parameter int W_X = c_w_x,
  parameter int W_Y = c_w_y
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W_X-1:0] x,
  input  logic [W_Y-1:0] y,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [W_X-1:0] q,
  output logic [W_Y-1:0] r,
  output logic           dz
);

  localparam int c_cw = $clog2(W_X);
  localparam logic [c_cw-1:0] c_last = c_cw'(W_X - 1);

  state_t         r_state;
  state_t         w_state_next;
  logic           w_accept;
  logic           w_y_zero;

  // Dividend bits leave at the MSB while quotient bits enter at the LSB, so
  // one register holds both; after W_X steps it contains the full quotient.
  logic [W_X-1:0] r_xq;
  logic [W_Y-1:0] r_y;
  logic [W_Y:0]   r_p;
  logic [c_cw-1:0] r_cnt;
  logic [W_X-1:0] r_q;
  logic [W_Y-1:0] r_r;
  logic           r_dz;

  logic [W_Y:0]   w_p_next;
  logic           w_q_bit;

  assign w_y_zero = (y == '0);
  assign w_accept = (r_state == IDLE) && in_valid;

  div_restore_step #(
    .W_Y (W_Y)
  ) u_step (
    .p_in  (r_p),
    .d_bit (r_xq[W_X-1]),
    .y     (r_y),
    .p_out (w_p_next),
    .q_bit (w_q_bit)
  );

  // --------------------------------------------------------------------------
  // FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_state_next = w_y_zero ? DONE : BUSY;
        end
      end
      BUSY: begin
        if (r_cnt == c_last) begin
          w_state_next = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath and result registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_xq  <= '0;
      r_y   <= '0;
      r_p   <= '0;
      r_cnt <= '0;
      r_q   <= '0;
      r_r   <= '0;
      r_dz  <= 1'b0;
    end else begin
      if (w_accept) begin
        if (w_y_zero) begin
          r_q  <= '1;
          r_r  <= '0;
          r_dz <= 1'b1;
        end else begin
          r_xq  <= x;
          r_y   <= y;
          r_p   <= '0;
          r_cnt <= '0;
        end
      end else if (r_state == BUSY) begin
        r_xq  <= {r_xq[W_X-2:0], w_q_bit};
        r_p   <= w_p_next;
        r_cnt <= r_cnt + 1'b1;
        if (r_cnt == c_last) begin
          r_q  <= {r_xq[W_X-2:0], w_q_bit};
          r_r  <= w_p_next[W_Y-1:0];
          r_dz <= 1'b0;
        end
      end
    end
  end

  assign q  = r_q;
  assign r  = r_r;
  assign dz = r_dz;

endmodule : unsigned_div_16by8_seq
`default_nettype wire
